// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared data-memory BRAM port between the main core and the subcores.
// Build option: define DMA_MAIN_PRIORITY_EN to give requester 0 absolute priority.
module data_mem_arbiter #(
  parameter int N_REQ     = 2,
  parameter int RD_LAT    = 2,
  parameter int MEM_DEPTH = 120000,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_addr,
  input  logic [N_REQ*32-1:0]  req_din,
  input  logic [N_REQ*4-1:0]   req_we,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_dout,
  output logic                 mem_en,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  output logic [3:0]           mem_we,
  input  logic [31:0]          mem_dout,
  output logic                 err_oob,
  output logic [IDW-1:0]       err_id
);

`ifdef DMA_MAIN_PRIORITY_EN
  localparam bit MAIN_PRIO = 1'b1;
`else
  localparam bit MAIN_PRIO = 1'b0;
`endif

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic [2*N_REQ-1:0] req_rot;
  logic [IDW:0]       cand;

  logic [31:0]        sel_addr;
  logic [31:0]        sel_din;
  logic [3:0]         sel_we;
  logic               sel_oob;
  logic               sel_load;

  logic               pipe_v   [RD_LAT];
  logic               pipe_oob [RD_LAT];
  logic [IDW-1:0]     pipe_id  [RD_LAT];

  // Doubling the request vector lets a plain right shift act as a rotate by rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    req_rot = {req_valid, req_valid} >> rr_ptr;
    if (MAIN_PRIO && req_valid[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!gnt_any && req_rot[k]) begin
          gnt_any = 1'b1;
          cand    = {1'b0, rr_ptr} + (IDW+1)'(k);
          if (cand >= (IDW+1)'(N_REQ))
            cand = cand - (IDW+1)'(N_REQ);
          gnt_idx = cand[IDW-1:0];
        end
      end
    end
    if (rst)
      gnt_any = 1'b0;
  end

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_addr = req_addr[32*i +: 32];
        sel_din  = req_din[32*i +: 32];
        sel_we   = req_we[4*i +: 4];
      end
    end
    sel_oob  = sel_addr >= 32'(MEM_DEPTH);
    sel_load = (sel_we == 4'b0000);
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = gnt_any && (gnt_idx == IDW'(i));
  end

  // Out-of-range accesses are accepted but never reach the BRAM.
  always_comb begin
    mem_en   = gnt_any && !sel_oob;
    mem_addr = mem_en ? sel_addr : 32'h0;
    mem_din  = mem_en ? sel_din  : 32'h0;
    mem_we   = mem_en ? sel_we   : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any && !(MAIN_PRIO && gnt_idx == '0)) begin
      if (gnt_idx == IDW'(N_REQ-1))
        rr_ptr <= '0;
      else
        rr_ptr <= gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v[s]   <= 1'b0;
        pipe_oob[s] <= 1'b0;
        pipe_id[s]  <= '0;
      end
    end else begin
      pipe_v[0]   <= gnt_any && sel_load;
      pipe_oob[0] <= sel_oob;
      pipe_id[0]  <= gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_oob[s] <= pipe_oob[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_dout  = '0;
    if (!rst && pipe_v[RD_LAT-1]) begin
      for (int i = 0; i < N_REQ; i++)
        rsp_valid[i] = (pipe_id[RD_LAT-1] == IDW'(i));
      if (!pipe_oob[RD_LAT-1])
        rsp_dout = mem_dout;
    end
  end

  // err_id records only the first offender; later ones leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
      err_id  <= '0;
    end else if (gnt_any && sel_oob && !err_oob) begin
      err_oob <= 1'b1;
      err_id  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed cases plus random traffic against
// a transaction-level model (grant order, memory image, response queue).
module tb_data_mem_arbiter;

  localparam int N     = 2;
  localparam int LAT   = 2;
  localparam int DEPTH = 120000;
`ifdef DMA_MAIN_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_din;
  logic [N*4-1:0]  req_we;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_dout;
  logic            mem_en;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_din;
  logic [3:0]      mem_we;
  logic [31:0]     mem_dout;
  logic            err_oob;
  logic [0:0]      err_id;

  data_mem_arbiter #(.N_REQ(N), .RD_LAT(LAT), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_din(req_din), .req_we(req_we),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .err_oob(err_oob), .err_id(err_id)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM: address registered, then output registered.
  logic [31:0] bram [DEPTH];
  logic [31:0] rd_s1;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      rd_s1 <= bram[mem_addr];
    end
    mem_dout <= rd_s1;
  end

  typedef struct { int due; int id; logic [31:0] data; } rsp_t;
  rsp_t        rq[$];
  logic [31:0] ref_mem [DEPTH];
  int          m_ptr;
  bit          m_err;
  int          m_eid;

  logic        drv_rst;
  logic [N-1:0] drv_v;
  logic [31:0] drv_addr [N];
  logic [31:0] drv_din  [N];
  logic [3:0]  drv_we   [N];
  logic [N-1:0] granted;
  int          cyc;
  int          n_chk;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle, compare against the model at negedge, then advance the model.
  task automatic step();
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    logic [31:0]  erd;
    logic [31:0]  a;
    logic [31:0]  w;
    int           g;
    int           idx;
    bit           oob;
    rsp_t         r;
    rst = drv_rst;
    req_valid = drv_v;
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = drv_addr[i];
      req_din[32*i +: 32]  = drv_din[i];
      req_we[4*i +: 4]     = drv_we[i];
    end
    @(negedge clk);
    g = -1;
    if (!drv_rst) begin
      if (PRIO && drv_v[0]) g = 0;
      else
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && drv_v[idx]) g = idx;
        end
    end
    eg = '0;
    a = 32'h0;
    oob = 1'b0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      a = drv_addr[g];
      oob = (a >= DEPTH);
    end
    check("req_ready", 32'(req_ready), 32'(eg));
    check("mem_en", 32'(mem_en), 32'((g >= 0) && !oob));
    if (g >= 0 && oob) begin
      check("mem_we_oob", 32'(mem_we), 32'h0);
    end else if (g >= 0) begin
      check("mem_addr", mem_addr, a);
      check("mem_din", mem_din, drv_din[g]);
      check("mem_we", 32'(mem_we), 32'(drv_we[g]));
    end else begin
      check("mem_idle", {mem_addr[15:0] | mem_din[15:0], 12'h0, mem_we}, 32'h0);
    end
    erv = '0;
    erd = 32'h0;
    if (!drv_rst && rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      erv[r.id] = 1'b1;
      erd = r.data;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(erv));
    check("rsp_dout", rsp_dout, erd);
    if (!drv_rst) begin
      check("err_oob", 32'(err_oob), 32'(m_err));
      check("err_id", 32'(err_id), 32'(m_eid));
    end
    if (drv_rst) begin
      rq.delete();
      m_ptr = 0;
      m_err = 1'b0;
      m_eid = 0;
    end else if (g >= 0) begin
      if (!(PRIO && g == 0)) m_ptr = (g + 1) % N;
      if (oob && !m_err) begin
        m_err = 1'b1;
        m_eid = g;
      end
      if (drv_we[g] == 4'h0) begin
        r.due = cyc + LAT;
        r.id = g;
        r.data = oob ? 32'h0 : ref_mem[a];
        rq.push_back(r);
      end else if (!oob) begin
        w = ref_mem[a];
        for (int b = 0; b < 4; b++)
          if (drv_we[g][b]) w[8*b +: 8] = drv_din[g][8*b +: 8];
        ref_mem[a] = w;
      end
    end
    granted = eg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    drv_v[i] = 1'b1;
    drv_addr[i] = a;
    drv_din[i] = d;
    drv_we[i] = w;
  endtask

  task automatic idle(input int n);
    drv_v = '0;
    for (int t = 0; t < n; t++) step();
  endtask

  task automatic serve(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bit got;
    got = 1'b0;
    drv_v = '0;
    set_req(i, a, d, w);
    for (int t = 0; t < 8 && !got; t++) begin
      step();
      got = granted[i];
    end
    if (!got) check("serve_timeout", 32'h0, 32'h1);
    drv_v = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           pv [N];
    logic [31:0]  pa [N];
    logic [31:0]  pd [N];
    logic [3:0]   pw [N];
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    m_ptr = 0;
    m_err = 1'b0;
    m_eid = 0;
    rd_s1 = '0;
    mem_dout = '0;
    for (int i = 0; i < 64; i++) begin
      bram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bram[5] = 32'h0000_ABCD;  ref_mem[5] = 32'h0000_ABCD;
    bram[6] = 32'h6666_0006;  ref_mem[6] = 32'h6666_0006;
    drv_v = '0;
    for (int i = 0; i < N; i++) begin
      drv_addr[i] = '0;
      drv_din[i] = '0;
      drv_we[i] = '0;
      pv[i] = 1'b0;
      pa[i] = '0;
      pd[i] = '0;
      pw[i] = '0;
    end

    drv_rst = 1'b1;
    idle(3);
    drv_rst = 1'b0;
    idle(1);

    set_req(0, 32'd5, 32'h0, 4'h0);
    step();
    idle(3);

    drv_v = '0;
    set_req(0, 32'd5, 32'h0, 4'h0);
    set_req(1, 32'd6, 32'h0, 4'h0);
    for (int t = 0; t < 8; t++) step();
    idle(3);

    serve(1, 32'd7, 32'h1122_3344, 4'b0011);
    serve(1, 32'd7, 32'h0, 4'h0);
    idle(3);

    serve(1, 32'd120000, 32'h0, 4'h0);
    idle(3);
    serve(0, 32'd120005, 32'hDEAD_BEEF, 4'hF);
    idle(2);

    serve(0, 32'd5, 32'h0, 4'h0);
    drv_rst = 1'b1;
    idle(1);
    drv_rst = 1'b0;
    idle(3);
    set_req(0, 32'd6, 32'h0, 4'h0);
    set_req(1, 32'd5, 32'h0, 4'h0);
    step();
    idle(3);

    // Random traffic: each requester holds its request until the model grants it.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 99) < 5) ? 32'(DEPTH + $urandom_range(0, 100))
                                              : 32'($urandom_range(0, 31));
          pd[i] = $urandom;
          pw[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
        drv_v[i] = pv[i];
        drv_addr[i] = pa[i];
        drv_din[i] = pd[i];
        drv_we[i] = pw[i];
      end
      step();
      for (int i = 0; i < N; i++)
        if (granted[i]) pv[i] = 1'b0;
    end
    idle(4);
    check("drain", 32'(rq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single data-memory BRAM port between the main core (requester 0) and `SUBCORE_NUM` subcores (requesters 1..N-1). Each cycle it grants at most one `Load`/`Store` access, drives the BRAM address/data/byte-write-enable port, and routes read data back to the issuing requester after the fixed BRAM latency. It sits between the cores' memory stages and the `DATA_MEM_DEPTH`-word data BRAM.

## Interface
- `N_REQ`, default `SUBCORE_NUM+1` (2): number of requesters; requester 0 is the main core.
- `RD_LAT`, default 2: BRAM read latency in cycles, from enable to valid `mem_dout`; legal range 1..4.
- `MEM_DEPTH`, default `DATA_MEM_DEPTH` (120000): number of valid word addresses.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  one access request per requester.
- `req_addr`  in  N_REQ*32  word address; requester i occupies bits [32i+31:32i].
- `req_din`  in  N_REQ*32  store data.
- `req_we`  in  N_REQ*4  byte write enables; 0 means load, nonzero means store.
- `req_ready`  out  N_REQ  one-hot grant: the request is accepted this cycle.
- `rsp_valid`  out  N_REQ  load data valid for requester i.
- `rsp_dout`  out  32  load data, shared by all requesters and qualified by `rsp_valid`.
- `mem_en`  out  1  BRAM enable.
- `mem_addr`  out  32  BRAM word address.
- `mem_din`  out  32  BRAM write data.
- `mem_we`  out  4  BRAM byte write enables.
- `mem_dout`  in  32  BRAM read data.
- `err_oob`  out  1  sticky flag: an out-of-range access has occurred.
- `err_id`  out  $clog2(N_REQ)  requester that caused the first out-of-range access.

## Operation
- **Grant:** combinational round-robin over `req_valid`, starting at `rr_ptr`. At most one `req_ready` bit is high per cycle, and `req_ready[i]` never goes high without `req_valid[i]`.
- **Requester obligation:** hold `req_valid` and all payload stable until `req_ready` is seen. The arbiter does not check this.
- **Pointer update:** on a grant to requester g, `rr_ptr <= (g+1) mod N_REQ`. With no grant, `rr_ptr` holds.
- **Memory drive (in-range grant):** `mem_en=1`, `mem_addr/mem_din/mem_we` copied from the granted requester in the same cycle.
- **Memory drive (no grant):** `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`.
- **Store:** completes at acceptance. No response is returned.
- **Load:** the response pipeline records {valid, requester id, oob} per accepted load. The pipeline is a shift register of depth `RD_LAT`.
- **Out of range** (`req_addr >= MEM_DEPTH`):
  - The request is still accepted, but `mem_en=0` and `mem_we=0`.
  - A load still returns a response, with `rsp_dout=0`.
  - `err_oob` is set; `err_id` is captured only on the 0→1 transition of `err_oob`.
  - Both flags clear only on reset.
- **Responses:** loads return strictly in acceptance order. At most one `rsp_valid` bit is high per cycle.

## Timing
- Grant and memory-port outputs are combinational from `req_valid`/`req_addr` and `rr_ptr`. There is no added cycle.
- A load accepted in cycle T asserts `rsp_valid[i]` in cycle T+`RD_LAT`, with `rsp_dout = mem_dout` in that cycle (0 if oob).
- Throughput: one access per cycle. Back-to-back loads from different requesters produce responses in consecutive cycles.
- Reset values:
  - `rr_ptr=0`, pipeline empty.
  - `rsp_valid=0`, `rsp_dout=0`.
  - `err_oob=0`, `err_id=0`.
  - `req_ready` is forced to 0 while `rst=1`, which forces the memory port idle.
- Reset mid-operation: all in-flight loads are dropped, and no `rsp_valid` is produced for them after reset deasserts.
- Simultaneous requests: the winner is the first set bit at or after `rr_ptr` (cyclic). Losers keep `req_valid` and are served within N_REQ-1 cycles.
- `N_REQ=1`: the grant is `req_valid[0]` and `rr_ptr` stays 0.

## Configuration
- `DMA_MAIN_PRIORITY_EN` defined: requester 0 wins whenever `req_valid[0]=1`. Round-robin applies only among requesters 1..N-1, and `rr_ptr` is not updated on main-core grants. Subcores may starve while the main core streams accesses.
- Macro undefined: pure round-robin over all requesters, as described under Operation.

## Test plan
- **Single load after reset:** mem[5]=0x0000_ABCD; req 0 loads addr 5 at T. Expect `req_ready[0]` at T, `mem_en=1`, `mem_addr=5`, then `rsp_valid=2'b01` and `rsp_dout=0x0000_ABCD` at T+2.
- **Contention:** both requesters hold loads continuously. Expect grants alternating 0,1,0,1 and responses alternating at lag 2. With `DMA_MAIN_PRIORITY_EN`, expect req 0 granted every cycle and `req_ready[1]=0`.
- **Byte store then load:** req 1 stores `din=0x1122_3344`, `we=4'b0011` to addr 7 (initially 0), then loads addr 7. Expect `rsp_dout=0x0000_3344` on `rsp_valid[1]`.
- **Out of range:** req 1 loads addr 120000. Expect accepted, `mem_en=0`, `rsp_valid[1]` with `rsp_dout=0` after 2 cycles, `err_oob=1`, `err_id=1`. A later oob access from req 0 leaves `err_id=1`.
- **Reset mid-flight:** assert `rst` one cycle after a load is accepted. Expect no `rsp_valid` in any later cycle, all outputs at reset values, and `rr_ptr` back at 0 (next simultaneous request granted to req 0).
